// File: rtl/pic_int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pic_int_ctrl_pkg
// Shared definitions for the interrupt/sleep/wake sequencer:
//   - INTCON bit positions (GIE down to RBIF)
//   - sequencer state encoding (RUN, PEND, VEC, SLEEP)
//   - register-file address of INTCON for the SFR decoder
// ---------------------------------------------------------------------------
package pic_int_ctrl_pkg;

    localparam int GIE_BIT  = 7;
    localparam int EEIE_BIT = 6;
    localparam int T0IE_BIT = 5;
    localparam int INTE_BIT = 4;
    localparam int RBIE_BIT = 3;
    localparam int T0IF_BIT = 2;
    localparam int INTF_BIT = 1;
    localparam int RBIF_BIT = 0;

    localparam logic [7:0] INTCON_ADDR = 8'h0B;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_VEC   = 2'd2,
        ST_SLEEP = 2'd3
    } pic_state_e;

endpackage

// File: rtl/pic_pin_sync.sv
// ---------------------------------------------------------------------------
// pic_pin_sync
// WIDTH-bit, STAGES-deep flop chain that brings asynchronous pin levels into
// the core clock domain. Cleared to zero by the asynchronous active-low reset.
// Ports:
//   clk   - core clock
//   rst_n - asynchronous active-low clear
//   d     - raw asynchronous input
//   q     - synchronized output (last stage)
// ---------------------------------------------------------------------------
module pic_pin_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 samples the pin, each later stage re-samples the
    // one before it to let metastability settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pic_int_ctrl.sv
// ---------------------------------------------------------------------------
// pic_int_ctrl
// Interrupt, sleep and wake sequencer. Owns INTCON, detects RB0/INT edges and
// RB<7:4> changes, latches the TMR0 overflow, and raises the interrupt vector
// request at an instruction boundary. A WDT timeout wakes the core from SLEEP
// or, while awake, requests a device reset.
// Ports:
//   clkout, rst_n                 - core clock, async active-low reset
//   intcon_reg_in/intcon_wr_en    - software write of INTCON
//   intcon_reg_out                - current INTCON
//   tmr0if_set_en, wdt_timeout    - strobes from the TMR0/WDT block
//   eeif                          - EEPROM write-complete level
//   intedg, rb0_pin               - RB0/INT edge select and raw pin
//   rb_hi_pin, trisb_hi           - raw RB<7:4> pins and their direction
//   portb_rd_en                   - PORTB read, reloads the change latch
//   instr_boundary                - current instruction completes
//   retfie_en, sleep_en           - RETFIE / SLEEP executing
//   int_vector_en                 - one-cycle vector request to the core
//   asleep                        - core stall while sleeping
//   wake_pulse                    - one-cycle pulse on leaving SLEEP
//   wdt_reset_req                 - one-cycle device reset request
// ---------------------------------------------------------------------------
module pic_int_ctrl
    import pic_int_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] INTCON_RST  = 8'h00
) (
    input  logic       clkout,
    input  logic       rst_n,
    input  logic [7:0] intcon_reg_in,
    input  logic       intcon_wr_en,
    output logic [7:0] intcon_reg_out,
    input  logic       tmr0if_set_en,
    input  logic       wdt_timeout,
    input  logic       eeif,
    input  logic       intedg,
    input  logic       rb0_pin,
    input  logic [3:0] rb_hi_pin,
    input  logic [3:0] trisb_hi,
    input  logic       portb_rd_en,
    input  logic       instr_boundary,
    input  logic       retfie_en,
    input  logic       sleep_en,
    output logic       int_vector_en,
    output logic       asleep,
    output logic       wake_pulse,
    output logic       wdt_reset_req
);

    pic_state_e state_q, state_d;
    logic [7:0] intcon_q, intcon_d;
    logic       rb0_sync, rb0_prev;
    logic [3:0] rb_hi_sync, rb_latch;
    logic       wake_q, wake_d;
    logic       wdt_req_q, wdt_req_d;
    logic       int_edge, rb_change, pending, gie_pending;

    pic_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rb0_sync (
        .clk   (clkout),
        .rst_n (rst_n),
        .d     (rb0_pin),
        .q     (rb0_sync)
    );

    pic_pin_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_rb_hi_sync (
        .clk   (clkout),
        .rst_n (rst_n),
        .d     (rb_hi_pin),
        .q     (rb_hi_sync)
    );

    assign int_edge  = intedg ? (rb0_sync & ~rb0_prev) : (~rb0_sync & rb0_prev);
    assign rb_change = |((rb_hi_sync ^ rb_latch) & trisb_hi);

    assign pending = (intcon_q[T0IE_BIT] & intcon_q[T0IF_BIT])
                   | (intcon_q[INTE_BIT] & intcon_q[INTF_BIT])
                   | (intcon_q[RBIE_BIT] & intcon_q[RBIF_BIT])
                   | (intcon_q[EEIE_BIT] & eeif);
    assign gie_pending = intcon_q[GIE_BIT] & pending;

    // INTCON next value. Hardware flag sets are applied after the software
    // write so a same-cycle clear can never swallow an event. GIE is cleared
    // by the vector cycle ahead of RETFIE and the software write.
    always_comb begin
        intcon_d = intcon_q;
        if (intcon_wr_en) begin
            intcon_d = intcon_reg_in;
        end
        if (tmr0if_set_en) intcon_d[T0IF_BIT] = 1'b1;
        if (int_edge)      intcon_d[INTF_BIT] = 1'b1;
        if (rb_change)     intcon_d[RBIF_BIT] = 1'b1;
        if (state_q == ST_VEC) begin
            intcon_d[GIE_BIT] = 1'b0;
        end else if (retfie_en) begin
            intcon_d[GIE_BIT] = 1'b1;
        end
    end

    // Sequencer next state and decoded outputs. A PEND whose qualified
    // request has gone away (GIE written low) falls back to RUN unvectored.
    always_comb begin
        state_d       = state_q;
        int_vector_en = 1'b0;
        asleep        = 1'b0;
        wake_d        = 1'b0;
        wdt_req_d     = wdt_timeout & (state_q != ST_SLEEP);
        case (state_q)
            ST_RUN: begin
                if (gie_pending) begin
                    state_d = ST_PEND;
                end else if (sleep_en) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_PEND: begin
                if (!gie_pending) begin
                    state_d = ST_RUN;
                end else if (instr_boundary) begin
                    state_d = ST_VEC;
                end
            end
            ST_VEC: begin
                int_vector_en = 1'b1;
                state_d       = ST_RUN;
            end
            ST_SLEEP: begin
                asleep = 1'b1;
                if (pending || wdt_timeout) begin
                    wake_d  = 1'b1;
                    state_d = gie_pending ? ST_PEND : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, INTCON, edge history, change latch and registered pulses.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            intcon_q  <= INTCON_RST;
            rb0_prev  <= 1'b0;
            rb_latch  <= 4'h0;
            wake_q    <= 1'b0;
            wdt_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            intcon_q  <= intcon_d;
            rb0_prev  <= rb0_sync;
            wake_q    <= wake_d;
            wdt_req_q <= wdt_req_d;
            if (portb_rd_en) begin
                rb_latch <= rb_hi_sync;
            end
        end
    end

    assign intcon_reg_out = intcon_q;
    assign wake_pulse     = wake_q;
    assign wdt_reset_req  = wdt_req_q;

endmodule

// File: tb/tb_pic_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pic_int_ctrl
// Directed bench for pic_int_ctrl with a cycle-level reference model and a
// per-cycle comparator, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_pic_int_ctrl;

    localparam int         SYNC = 2;
    localparam logic [7:0] RSTV = 8'h00;

    localparam int M_AWAKE   = 0;
    localparam int M_WAITING = 1;
    localparam int M_VECTOR  = 2;
    localparam int M_ASLEEP  = 3;

    logic       clkout = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] intcon_reg_in = 8'h00;
    logic       intcon_wr_en = 1'b0;
    logic [7:0] intcon_reg_out;
    logic       tmr0if_set_en = 1'b0;
    logic       wdt_timeout = 1'b0;
    logic       eeif = 1'b0;
    logic       intedg = 1'b0;
    logic       rb0_pin = 1'b0;
    logic [3:0] rb_hi_pin = 4'h0;
    logic [3:0] trisb_hi = 4'h0;
    logic       portb_rd_en = 1'b0;
    logic       instr_boundary = 1'b1;
    logic       retfie_en = 1'b0;
    logic       sleep_en = 1'b0;
    logic       int_vector_en;
    logic       asleep;
    logic       wake_pulse;
    logic       wdt_reset_req;

    int vectors_applied = 0;
    int miscompares = 0;

    // reference model state
    logic [7:0] m_intcon = RSTV;
    int         m_mode = M_AWAKE;
    logic       m_wake = 1'b0;
    logic       m_wdt_req = 1'b0;
    logic       m_rb0_hist [0:3] = '{default: 1'b0};
    logic [3:0] m_hi_hist  [0:3] = '{default: 4'h0};
    logic [3:0] m_latch = 4'h0;
    logic       m_pend, m_gie, m_cur0, m_prv0, m_edge, m_change;
    logic [3:0] m_curhi;
    logic [7:0] m_next;

    pic_int_ctrl #(.SYNC_STAGES(SYNC), .INTCON_RST(RSTV)) dut (
        .clkout         (clkout),
        .rst_n          (rst_n),
        .intcon_reg_in  (intcon_reg_in),
        .intcon_wr_en   (intcon_wr_en),
        .intcon_reg_out (intcon_reg_out),
        .tmr0if_set_en  (tmr0if_set_en),
        .wdt_timeout    (wdt_timeout),
        .eeif           (eeif),
        .intedg         (intedg),
        .rb0_pin        (rb0_pin),
        .rb_hi_pin      (rb_hi_pin),
        .trisb_hi       (trisb_hi),
        .portb_rd_en    (portb_rd_en),
        .instr_boundary (instr_boundary),
        .retfie_en      (retfie_en),
        .sleep_en       (sleep_en),
        .int_vector_en  (int_vector_en),
        .asleep         (asleep),
        .wake_pulse     (wake_pulse),
        .wdt_reset_req  (wdt_reset_req)
    );

    always #5 clkout = ~clkout;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // advance n rising edges, then settle just past the last one
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clkout);
        #1;
    endtask

    task automatic writeIntcon(input logic [7:0] v);
        intcon_reg_in = v;
        intcon_wr_en  = 1'b1;
        applyStimulus(1);
        intcon_wr_en  = 1'b0;
    endtask

    // Reference model: one step per clock, from the behavioural rules.
    // The synchronized pin seen at an edge is the pin sampled SYNC edges
    // earlier; the edge history is the sample one edge before that.
    always @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            m_intcon  = RSTV;
            m_mode    = M_AWAKE;
            m_wake    = 1'b0;
            m_wdt_req = 1'b0;
            m_latch   = 4'h0;
            for (int j = 0; j < 4; j++) begin
                m_rb0_hist[j] = 1'b0;
                m_hi_hist[j]  = 4'h0;
            end
        end else begin
            m_pend = (m_intcon[5] && m_intcon[2]) || (m_intcon[4] && m_intcon[1])
                  || (m_intcon[3] && m_intcon[0]) || (m_intcon[6] && eeif);
            m_gie    = m_intcon[7];
            m_cur0   = m_rb0_hist[SYNC-1];
            m_prv0   = m_rb0_hist[SYNC];
            m_edge   = (m_cur0 != m_prv0) && (m_cur0 == intedg);
            m_curhi  = m_hi_hist[SYNC-1];
            m_change = ((m_curhi ^ m_latch) & trisb_hi) != 4'h0;

            m_next = intcon_wr_en ? intcon_reg_in : m_intcon;
            m_next = m_next | {5'b0, tmr0if_set_en, m_edge, m_change};
            if (m_mode == M_VECTOR) m_next[7] = 1'b0;
            else if (retfie_en)     m_next[7] = 1'b1;

            m_wdt_req = wdt_timeout && (m_mode != M_ASLEEP);
            m_wake    = (m_mode == M_ASLEEP) && (m_pend || wdt_timeout);

            if (m_mode == M_AWAKE) begin
                if (m_gie && m_pend) m_mode = M_WAITING;
                else if (sleep_en)   m_mode = M_ASLEEP;
            end else if (m_mode == M_WAITING) begin
                if (!(m_gie && m_pend)) m_mode = M_AWAKE;
                else if (instr_boundary) m_mode = M_VECTOR;
            end else if (m_mode == M_VECTOR) begin
                m_mode = M_AWAKE;
            end else if (m_pend || wdt_timeout) begin
                m_mode = (m_gie && m_pend) ? M_WAITING : M_AWAKE;
            end

            if (portb_rd_en) m_latch = m_curhi;
            for (int j = 3; j > 0; j--) begin
                m_rb0_hist[j] = m_rb0_hist[j-1];
                m_hi_hist[j]  = m_hi_hist[j-1];
            end
            m_rb0_hist[0] = rb0_pin;
            m_hi_hist[0]  = rb_hi_pin;
            m_intcon      = m_next;
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clkout) begin
        checkOutput("cyc_intcon", intcon_reg_out, m_intcon);
        checkOutput("cyc_vector", 8'(int_vector_en), 8'(m_mode == M_VECTOR));
        checkOutput("cyc_asleep", 8'(asleep), 8'(m_mode == M_ASLEEP));
        checkOutput("cyc_wake", 8'(wake_pulse), 8'(m_wake));
        checkOutput("cyc_wdtreq", 8'(wdt_reset_req), 8'(m_wdt_req));
    end

    initial begin
        // reset state
        applyStimulus(2);
        checkOutput("rst_intcon", intcon_reg_out, 8'h00);
        checkOutput("rst_vector", 8'(int_vector_en), 8'h00);
        checkOutput("rst_asleep", 8'(asleep), 8'h00);
        rst_n = 1'b1;
        applyStimulus(1);

        // TMR0 interrupt through PEND and VEC
        writeIntcon(8'hA0);
        tmr0if_set_en = 1'b1;
        applyStimulus(1);
        tmr0if_set_en = 1'b0;
        checkOutput("t0_flag", intcon_reg_out, 8'hA4);
        applyStimulus(1);
        checkOutput("t0_pend_novec", 8'(int_vector_en), 8'h00);
        applyStimulus(1);
        checkOutput("t0_vec", 8'(int_vector_en), 8'h01);
        applyStimulus(1);
        checkOutput("t0_vec_done", 8'(int_vector_en), 8'h00);
        checkOutput("t0_intcon", intcon_reg_out, 8'h24);
        writeIntcon(8'h00);

        // RB0 falling edge with intedg=0, then falling edge with intedg=1
        writeIntcon(8'h10);
        rb0_pin = 1'b1;
        applyStimulus(4);
        checkOutput("int_rise_ignored", intcon_reg_out, 8'h10);
        rb0_pin = 1'b0;
        applyStimulus(2);
        checkOutput("intf_latency", intcon_reg_out, 8'h10);
        applyStimulus(1);
        checkOutput("intf_set", intcon_reg_out, 8'h12);
        writeIntcon(8'h10);
        rb0_pin = 1'b1;
        applyStimulus(5);
        intedg  = 1'b1;
        rb0_pin = 1'b0;
        applyStimulus(5);
        checkOutput("intf_wrong_edge", intcon_reg_out, 8'h10);
        writeIntcon(8'h00);

        // sleep, RB<7:4> change wakes without a vector
        trisb_hi = 4'hF;
        writeIntcon(8'h08);
        sleep_en = 1'b1;
        applyStimulus(1);
        sleep_en = 1'b0;
        checkOutput("rb_asleep", 8'(asleep), 8'h01);
        rb_hi_pin = 4'h1;
        applyStimulus(2);
        checkOutput("rbif_latency", intcon_reg_out, 8'h08);
        applyStimulus(1);
        checkOutput("rbif_set", intcon_reg_out, 8'h09);
        applyStimulus(1);
        checkOutput("rb_wake", 8'(wake_pulse), 8'h01);
        checkOutput("rb_awake", 8'(asleep), 8'h00);
        applyStimulus(1);
        checkOutput("rb_wake_once", 8'(wake_pulse), 8'h00);
        portb_rd_en = 1'b1;
        applyStimulus(1);
        portb_rd_en = 1'b0;
        writeIntcon(8'h08);
        applyStimulus(2);
        checkOutput("rbif_stays_clear", intcon_reg_out, 8'h08);

        // hardware set beats a same-cycle software clear
        writeIntcon(8'h24);
        intcon_reg_in = 8'h20;
        intcon_wr_en  = 1'b1;
        tmr0if_set_en = 1'b1;
        applyStimulus(1);
        intcon_wr_en  = 1'b0;
        tmr0if_set_en = 1'b0;
        checkOutput("t0if_hw_wins", intcon_reg_out, 8'h24);
        writeIntcon(8'h00);

        // WDT awake -> reset request; WDT asleep -> wake only
        wdt_timeout = 1'b1;
        applyStimulus(1);
        wdt_timeout = 1'b0;
        checkOutput("wdt_req", 8'(wdt_reset_req), 8'h01);
        applyStimulus(1);
        checkOutput("wdt_req_once", 8'(wdt_reset_req), 8'h00);
        sleep_en = 1'b1;
        applyStimulus(1);
        sleep_en = 1'b0;
        applyStimulus(2);
        checkOutput("wdt_still_asleep", 8'(asleep), 8'h01);
        wdt_timeout = 1'b1;
        applyStimulus(1);
        wdt_timeout = 1'b0;
        checkOutput("wdt_wake", 8'(wake_pulse), 8'h01);
        checkOutput("wdt_no_req", 8'(wdt_reset_req), 8'h00);
        checkOutput("wdt_awake", 8'(asleep), 8'h00);

        // EEPROM level interrupt, then RETFIE re-arms GIE
        writeIntcon(8'hC0);
        eeif = 1'b1;
        applyStimulus(2);
        checkOutput("ee_vec", 8'(int_vector_en), 8'h01);
        applyStimulus(1);
        checkOutput("ee_gie_cleared", intcon_reg_out, 8'h40);
        retfie_en = 1'b1;
        applyStimulus(1);
        retfie_en = 1'b0;
        checkOutput("retfie_gie", intcon_reg_out, 8'hC0);
        applyStimulus(2);
        checkOutput("ee_revec", 8'(int_vector_en), 8'h01);
        eeif = 1'b0;
        applyStimulus(1);
        writeIntcon(8'h00);

        // GIE written low while pending: no vector; SLEEP ignored in PEND
        instr_boundary = 1'b0;
        writeIntcon(8'hA4);
        sleep_en = 1'b1;
        applyStimulus(1);
        sleep_en = 1'b0;
        checkOutput("pend_sleep_ignored", 8'(asleep), 8'h00);
        writeIntcon(8'h24);
        instr_boundary = 1'b1;
        applyStimulus(2);
        checkOutput("pend_drop_novec", 8'(int_vector_en), 8'h00);
        checkOutput("pend_drop_intcon", intcon_reg_out, 8'h24);
        writeIntcon(8'h00);

        // reset in the vector cycle
        writeIntcon(8'hA0);
        tmr0if_set_en = 1'b1;
        applyStimulus(1);
        tmr0if_set_en = 1'b0;
        applyStimulus(2);
        checkOutput("vec_before_rst", 8'(int_vector_en), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_vec_abort", 8'(int_vector_en), 8'h00);
        checkOutput("rst_vec_intcon", intcon_reg_out, 8'h00);
        checkOutput("rst_vec_asleep", 8'(asleep), 8'h00);
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/pic_int_ctrl.md
Name: pic_int_ctrl

Overview:
- Interrupt, sleep and wake sequencer that sits directly downstream of the TMR0/WDT block.
- Consumes that block's T0IF set strobe and WDT timeout, plus the RB0/INT pin, RB<7:4> change and EEPROM-done events.
- Owns the INTCON register and raises the vector request to the core at an instruction boundary.
- Also turns a WDT timeout into either a wake (during SLEEP) or a device-reset request.

Parameters:
SYNC_STAGES, 2, number of flops in the RB0 and RB<7:4> pin synchronizers (2 or 3 allowed)
INTCON_RST, 8'h00, INTCON value after reset

Ports:
clkout  in  1  core clock (Fosc/4); all state on its rising edge
rst_n  in  1  asynchronous active-low reset
intcon_reg_in  in  8  write data for INTCON: GIE(7) EEIE(6) T0IE(5) INTE(4) RBIE(3) T0IF(2) INTF(1) RBIF(0)
intcon_wr_en  in  1  write INTCON this cycle
intcon_reg_out  out  8  current INTCON
tmr0if_set_en  in  1  TMR0 overflow strobe from the timer block
wdt_timeout  in  1  WDT overflow strobe from the timer block
eeif  in  1  EEPROM write-complete flag (level)
intedg  in  1  OPTION.INTEDG; 1 = rising edge on RB0, 0 = falling
rb0_pin  in  1  raw RB0/INT pin (asynchronous)
rb_hi_pin  in  4  raw RB<7:4> pins (asynchronous)
trisb_hi  in  4  TRISB<7:4>; 1 = input, only input pins take part in change detection
portb_rd_en  in  1  PORTB read this cycle; reloads the RB<7:4> compare latch
instr_boundary  in  1  current instruction completes this cycle
retfie_en  in  1  RETFIE executing; sets GIE
sleep_en  in  1  SLEEP instruction executing
int_vector_en  out  1  one-cycle pulse: core pushes PC and loads 0x004
asleep  out  1  core must stall while high
wake_pulse  out  1  one-cycle pulse on exit from SLEEP
wdt_reset_req  out  1  one-cycle request for a device reset (WDT timeout while awake)

Behaviour:
- Reset (async, rst_n=0): INTCON=INTCON_RST; int_vector_en=0; asleep=0; wake_pulse=0; wdt_reset_req=0; FSM=RUN; synchronizers, RB compare latch and edge history cleared to 0.
- Pin inputs go through SYNC_STAGES flops before any use.
- INTF edge detect: compare the synchronized RB0 with its previous value. If intedg=1, INTF sets on 0->1; if intedg=0, INTF sets on 1->0. Latency is SYNC_STAGES+1 cycles from the pin to INTF.
- RBIF: set on every cycle where (sync_rb_hi XOR rb_latch) AND trisb_hi is nonzero. rb_latch loads sync_rb_hi when portb_rd_en=1.
- T0IF sets on the cycle after tmr0if_set_en=1.
- Flag register update priority, per flag bit: hardware set beats software write beats hold. Hardware set wins over a same-cycle software clear, so no event is lost.
- Pending = (T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (EEIE&eeif).
- FSM states: RUN, PEND, VEC, SLEEP.
  - RUN: if GIE&pending, go to PEND. Else if sleep_en, go to SLEEP.
  - PEND: wait for instr_boundary=1, then go to VEC.
  - VEC: int_vector_en=1 for exactly one cycle and GIE clears in the same cycle, then RUN. If pending has dropped while in PEND because GIE was cleared by a write, return to RUN with no vector.
  - SLEEP: asleep=1.
    - Exit on pending (GIE ignored) or on wdt_timeout, with wake_pulse=1 for one cycle.
    - After exit: if GIE&pending, go to PEND; otherwise RUN.
- GIE update priority: vector clear > retfie_en set > intcon_wr_en > hold.
- WDT:
  - wdt_timeout in SLEEP gives a wake only, never wdt_reset_req.
  - wdt_timeout in RUN, PEND or VEC gives wdt_reset_req=1 for one cycle on the next edge; all other state in this block is unchanged.
- sleep_en while in PEND or VEC is ignored (interrupt takes precedence).
- Reset asserted mid-vector aborts immediately; int_vector_en goes to 0 asynchronously.
- eeif is an external level; it is not stored in INTCON.

Decomposition:
- Shared package holds:
  - INTCON bit index constants (GIE=7 ... RBIF=0);
  - the FSM state encoding (RUN, PEND, VEC, SLEEP, 2 bits);
  - INTCON_ADDR=8'h0B for the register-file decoder.
- One sub-module: pic_pin_sync, a parameterized N-bit, SYNC_STAGES-deep synchronizer with async active-low clear. It is instanced for RB0 (1 bit) and RB<7:4> (4 bits).

Test Plan:
- Write INTCON=8'hA0 (GIE, T0IE), then pulse tmr0if_set_en with instr_boundary=1 -> T0IF=1 next cycle, FSM goes to PEND then VEC, int_vector_en pulses once, INTCON reads 8'h24.
- intedg=0, INTE=1, GIE=0, rb0_pin 1->0 -> INTF=1 after 3 cycles, no int_vector_en. Flip intedg=1 with a falling edge -> no INTF set.
- Sleep with INTCON=8'h08, trisb_hi=4'hF, rb_latch=0, then rb_hi_pin=4'h1 -> RBIF=1, wake_pulse once, asleep=0, no vector (GIE=0). portb_rd_en then write RBIF=0 -> RBIF stays 0.
- Same cycle: tmr0if_set_en=1 and write INTCON=8'h20 (clearing T0IF) -> T0IF=1 afterwards.
- wdt_timeout while awake -> wdt_reset_req=1 for one cycle. wdt_timeout while asleep -> wake_pulse=1, wdt_reset_req stays 0.
- Drop rst_n in VEC -> int_vector_en=0 immediately, INTCON=8'h00, asleep=0.
